axis_result_tx: RTL and testbench
=================================

# axis_result_tx

Result-side AXI-Stream transmitter for the matrix-multiply accelerator. After the `top` core finishes, this block reads its output BRAM word by word and sends the words on an AXI-Stream master toward the S2MM FIFO/DMA. It is the transmit counterpart of the input/weight stream-to-BRAM loader. It tolerates arbitrary `m_axis_tready` backpressure and BRAM read latency without losing words or stalling the BRAM pipeline incorrectly.

## Interface

**Parameters**
- `WIDTH`, 16: fixed-point element width.
- `CHUNK_SIZE`, 4: elements per core per word.
- `NUM_CORES`, 2: parallel cores; word width is `DATA_W = WIDTH*CHUNK_SIZE*NUM_CORES` (default 128).
- `NUM_WORDS`, 9: words per frame, ≥1 (`ROW_SIZE_MAT_C*COL_SIZE_MAT_C`).
- `ADDR_W`, 4: BRAM address width, ≥ clog2(`NUM_WORDS`).
- `BRAM_LAT`, 2: BRAM read latency in cycles, 1 or 2.

**Ports**
- `aclk`, in, 1: single clock. All logic is on the rising edge.
- `areset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request to send one frame; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done`, out, 1: one-cycle pulse after the tlast beat is accepted.
- `bram_en`, out, 1: BRAM read enable.
- `bram_addr`, out, `ADDR_W`: BRAM read address.
- `bram_dout`, in, `DATA_W`: BRAM read data, valid `BRAM_LAT` cycles after `bram_en`.
- `m_axis_tdata`, out, `DATA_W`: stream data.
- `m_axis_tvalid`, out, 1: stream valid.
- `m_axis_tready`, in, 1: stream ready.
- `m_axis_tlast`, out, 1: high on word `NUM_WORDS-1`.

## Operation

**States**
- IDLE → STREAM when `start` = 1. The address and issue counters clear.
- STREAM: issue reads for addresses 0..`NUM_WORDS-1` in order. Move to DRAIN in the cycle after the final read is issued.
- DRAIN: wait until no reads are in flight and the buffer is empty. Then go to DONE.
- DONE: `done` = 1 for one cycle, then return to IDLE.

**Buffering and credit**
- Output buffer is a FIFO of depth `DEPTH = BRAM_LAT+1`.
- A read is issued (`bram_en` = 1) only when `inflight + count − pop < DEPTH`.
  - `inflight` is the number of reads issued but not yet returned.
  - `pop` means `tvalid && tready` in the current cycle.
- Because of this credit rule, returning BRAM data always has a free slot and is never dropped or stalled.
- A `BRAM_LAT`-deep valid shift register tracks returning data. Each valid return pushes `bram_dout` into the FIFO.

**Outputs**
- `m_axis_tdata` and `m_axis_tlast` come from the FIFO head.
- `m_axis_tvalid` = !empty.
- tlast is stored alongside each word: it is set when the read for address `NUM_WORDS-1` is issued, delayed by `BRAM_LAT`.
- `bram_addr` holds its last value when `bram_en` = 0.

**AXIS rules**
- Once `tvalid` is asserted, `tvalid`, `tdata` and `tlast` stay stable until `tready` = 1.
- Exactly `NUM_WORDS` beats are sent per frame, and exactly one of them has tlast.

**Boundary conditions**
- `start` outside IDLE is ignored and does not queue a frame.
- `NUM_WORDS` = 1: a single beat carrying tlast.
- Push and pop in the same cycle, with the FIFO full: allowed; `count` is unchanged.
- `areset` mid-frame clears all state, `inflight` and the FIFO immediately. The partial frame is abandoned; no tlast is sent.

**Reset values**
- `busy`, `done`, `bram_en`, `m_axis_tvalid`, `m_axis_tlast` = 0.
- `bram_addr` = 0.
- `m_axis_tdata` = 0.
- State = IDLE.

## Timing

- With `start` sampled high in cycle 0:
  - cycle 1: STREAM, `bram_en` = 1, addr 0.
  - Read issued in cycle t: data on `bram_dout` in cycle t+`BRAM_LAT`, captured at the end of that cycle, `tvalid` visible in cycle t+`BRAM_LAT`+1.
  - So the first `tvalid` is in cycle `BRAM_LAT`+2.
- Throughput is 1 word/cycle while `tready` = 1.
- With `tready` held at 1, the frame takes `NUM_WORDS + BRAM_LAT + 2` cycles from `start` to `done`.
- `done` rises the cycle after the tlast handshake.
- `busy` falls in the cycle after `done`.
- The earliest next `start` is accepted in the cycle after `done`.

## Structure

- **Package `axis_result_pkg`:**
  - state enum: IDLE, STREAM, DRAIN, DONE;
  - `DATA_W` derivation function;
  - `DEPTH` helper.
- **Sub-module `axis_skid_fifo`:**
  - synchronous FIFO, `DATA_W`+1 bits wide (data + last), depth `DEPTH`;
  - ports: push, pop, count, empty, head;
  - async active-high reset.
- **Top FSM:** FSM, issue counter, `inflight` counter and latency valid pipe.

## Test plan

- `tready` = 1, `NUM_WORDS` = 9, `BRAM_LAT` = 2, BRAM[i] = i: `start` at cycle 0 → beats 0..8 in cycles 4..12, tlast only on beat 8, `done` in cycle 13.
- `tready` low for 5 cycles mid-frame: `tdata`/`tlast` stable, at most 3 reads outstanding plus buffered, no word lost or duplicated, 9 ordered beats.
- Random `tready` (50%) over 20 frames, with `BRAM_LAT` set to 1 and to 2: scoreboard matches BRAM contents, and each frame has exactly one tlast.
- `start` pulsed while `busy`: ignored; exactly one frame is sent.
- `NUM_WORDS` = 1: a single beat with tvalid and tlast together, then `done`.
- `areset` asserted after beat 3: all outputs go to 0 immediately. A new `start` then sends a full 9-beat frame beginning at word 0.

Source files
------------

// File: rtl/axis_result_pkg.sv
`default_nettype none
// ==================================================================
// axis_result_pkg : shared types and sizing helpers for axis_result_tx
// Rev 1.0
// ==================================================================
package axis_result_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int calc_data_w(input int width, input int chunk, input int cores);
        return width * chunk * cores;
    endfunction

    // One slot per possible in-flight read plus one so a word can be held while the next returns.
    function automatic int calc_depth(input int bram_lat);
        return bram_lat + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_fifo.sv
`default_nettype none
// ==================================================================
// axis_skid_fifo : small synchronous FIFO with combinational head output
// Rev 1.0
// ==================================================================
module axis_skid_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic [W-1:0]     head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // A push into a full FIFO is legal only alongside a pop; the slot being
            // overwritten is the head that is leaving this cycle.
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_result_tx.sv
`default_nettype none
// ==================================================================
// axis_result_tx : reads the result BRAM and streams it out on AXI-Stream
// Rev 1.0
// ==================================================================
module axis_result_tx
    import axis_result_pkg::*;
#(
    parameter int  WIDTH      = 16,
    parameter int  CHUNK_SIZE = 4,
    parameter int  NUM_CORES  = 2,
    parameter int  NUM_WORDS  = 9,
    parameter int  ADDR_W     = 4,
    parameter int  BRAM_LAT   = 2,
    localparam int DATA_W     = calc_data_w(WIDTH, CHUNK_SIZE, NUM_CORES)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int DEPTH = calc_depth(BRAM_LAT);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int IC_W  = ADDR_W + 1;
    localparam logic [IC_W-1:0] LAST_IDX  = IC_W'(NUM_WORDS - 1);
    localparam logic [IC_W-1:0] WORDS_CNT = IC_W'(NUM_WORDS);

    state_t            state;
    state_t            state_nx;
    logic [IC_W-1:0]   issue_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  count;
    logic [BRAM_LAT-1:0] vpipe;
    logic [BRAM_LAT-1:0] lpipe;
    logic              empty;
    logic              pop;
    logic              push;
    logic              credit_ok;
    logic              issue;
    logic              issue_last;
    logic              drained;
    logic [DATA_W:0]   head;

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign push = vpipe[BRAM_LAT-1];

    // Reserving a FIFO slot at issue time means returning data can never be refused.
    assign credit_ok  = (SUM_W'(inflight) + SUM_W'(count) - SUM_W'(pop)) < SUM_W'(DEPTH);
    assign issue      = (state == STREAM) && (issue_cnt < WORDS_CNT) && credit_ok;
    assign issue_last = issue && (issue_cnt == LAST_IDX);
    // Looks one cycle ahead so done follows the tlast handshake directly.
    assign drained    = (inflight == '0) && ((SUM_W'(count) - SUM_W'(pop)) == '0);

    assign bram_en   = issue;
    assign bram_addr = issue ? issue_cnt[ADDR_W-1:0] : addr_hold;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (issue_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drained) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            issue_cnt <= '0;
            addr_hold <= '0;
            inflight  <= '0;
            vpipe     <= '0;
            lpipe     <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                issue_cnt <= '0;
                addr_hold <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + IC_W'(1);
                addr_hold <= issue_cnt[ADDR_W-1:0];
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
            vpipe[0] <= issue;
            lpipe[0] <= issue_last;
            for (int i = 1; i < BRAM_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    axis_skid_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .pop   (pop),
        .din   ({lpipe[BRAM_LAT-1], bram_dout}),
        .count (count),
        .empty (empty),
        .head  (head)
    );

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = head[DATA_W-1:0];
    assign m_axis_tlast  = head[DATA_W] && !empty;

endmodule
`default_nettype wire

// File: tb/tb_axis_result_tx.sv
`default_nettype none
// ==================================================================
// tb_axis_result_tx : directed bench, three DUT configurations side by side
// Rev 1.0
// ==================================================================
module tb_axis_result_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              areset;
    logic [2:0]        start;
    logic [2:0]        tready;
    logic [2:0]        rnd_en;
    logic [2:0]        busy;
    logic [2:0]        done;
    logic [2:0]        bram_en;
    logic [2:0]        tvalid;
    logic [2:0]        tlast;
    logic [2:0][127:0] tdata;
    logic [3:0]        addr_a;
    logic [3:0]        addr_b;
    logic [0:0]        addr_c;
    logic [127:0]      st1_a, st2_a, st1_b, st1_c, st2_c;

    int checks = 0;
    int errors = 0;

    // Instance 0: 9 words, latency 2; instance 1: 9 words, latency 1; instance 2: 1 word, latency 2
    int nwords[3] = '{9, 9, 1};
    int depth[3]  = '{3, 2, 3};
    int beat[3]   = '{0, 0, 0};
    int lastc[3]  = '{0, 0, 0};
    int issued[3] = '{0, 0, 0};
    int popped[3] = '{0, 0, 0};
    int frames[3] = '{0, 0, 0};
    int exp_frames[3] = '{0, 0, 0};
    logic [2:0]        hold = '0;
    logic [2:0]        hlast = '0;
    logic [2:0][127:0] hdata = '0;

    function automatic logic [127:0] word_of(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {4{w}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    axis_result_tx #(.NUM_WORDS(9), .ADDR_W(4), .BRAM_LAT(2)) dut_a (
        .aclk(clk), .areset(areset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .bram_en(bram_en[0]), .bram_addr(addr_a), .bram_dout(st2_a),
        .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
        .m_axis_tlast(tlast[0])
    );

    axis_result_tx #(.NUM_WORDS(9), .ADDR_W(4), .BRAM_LAT(1)) dut_b (
        .aclk(clk), .areset(areset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .bram_en(bram_en[1]), .bram_addr(addr_b), .bram_dout(st1_b),
        .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
        .m_axis_tlast(tlast[1])
    );

    axis_result_tx #(.NUM_WORDS(1), .ADDR_W(1), .BRAM_LAT(2)) dut_c (
        .aclk(clk), .areset(areset), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .bram_en(bram_en[2]), .bram_addr(addr_c), .bram_dout(st2_c),
        .m_axis_tdata(tdata[2]), .m_axis_tvalid(tvalid[2]), .m_axis_tready(tready[2]),
        .m_axis_tlast(tlast[2])
    );

    // BRAM models: content of address i is word_of(i), output after 1 or 2 cycles
    always @(posedge clk) begin
        if (bram_en[0]) st1_a <= word_of(int'(addr_a));
        st2_a <= st1_a;
        if (bram_en[1]) st1_b <= word_of(int'(addr_b));
        if (bram_en[2]) st1_c <= word_of(int'(addr_c));
        st2_c <= st1_c;
    end

    // Stream monitor / scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (areset) begin
                beat[k] = 0; lastc[k] = 0; issued[k] = 0; popped[k] = 0; hold[k] = 1'b0;
            end else begin
                if (hold[k]) begin
                    check($sformatf("stall_valid[%0d]", k), 128'(tvalid[k]), 128'(1));
                    check($sformatf("stall_data[%0d]", k), tdata[k], hdata[k]);
                    check($sformatf("stall_last[%0d]", k), 128'(tlast[k]), 128'(hlast[k]));
                end
                if (tvalid[k] && tready[k]) begin
                    check($sformatf("beat_data[%0d]", k), tdata[k], word_of(beat[k]));
                    check($sformatf("beat_last[%0d]", k), 128'(tlast[k]),
                          128'(beat[k] == nwords[k] - 1));
                    if (tlast[k]) lastc[k]++;
                    beat[k]++;
                    popped[k]++;
                end
                if (bram_en[k]) begin
                    issued[k]++;
                    check($sformatf("credit[%0d]", k), 128'((issued[k] - popped[k]) <= depth[k]),
                          128'(1));
                end
                if (done[k]) begin
                    check($sformatf("frame_beats[%0d]", k), 128'(beat[k]), 128'(nwords[k]));
                    check($sformatf("frame_tlast[%0d]", k), 128'(lastc[k]), 128'(1));
                    frames[k]++;
                    beat[k] = 0; lastc[k] = 0; issued[k] = 0; popped[k] = 0;
                end
                hold[k]  = tvalid[k] && !tready[k];
                hdata[k] = tdata[k];
                hlast[k] = tlast[k];
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rnd_en[k]) tready[k] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic wait_frames(input logic [2:0] mask);
        bit all_done;
        for (int i = 0; i < 500; i++) begin
            all_done = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (mask[k] && frames[k] != exp_frames[k]) all_done = 1'b0;
            end
            if (all_done) break;
            step(1);
        end
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) check($sformatf("frame_count[%0d]", k), 128'(frames[k]), 128'(exp_frames[k]));
        end
    endtask

    task automatic run_frame(input logic [2:0] mask);
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                exp_frames[k]++;
                start[k] = 1'b1;
            end
        end
        step(1);
        start = '0;
        wait_frames(mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        start  = '0;
        tready = 3'b111;
        rnd_en = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   128'(busy[0]),    128'(0));
        check("rst_done",   128'(done[0]),    128'(0));
        check("rst_bram_en",128'(bram_en[0]), 128'(0));
        check("rst_tvalid", 128'(tvalid[0]),  128'(0));
        check("rst_tlast",  128'(tlast[0]),   128'(0));
        check("rst_addr",   128'(addr_a),     128'(0));
        check("rst_tdata",  tdata[0],         128'(0));
        @(posedge clk);
        #1 areset = 1'b0;
        step(2);

        // Full-rate timing: start in cycle 0, beats in cycles 4..12, done in 13
        exp_frames[0]++;
        start[0] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step(1);
            start[0] = 1'b0;
            @(negedge clk);
            check($sformatf("t_busy_c%0d", c),  128'(busy[0]),   128'(c <= 13));
            check($sformatf("t_valid_c%0d", c), 128'(tvalid[0]), 128'(c >= 4 && c <= 12));
            check($sformatf("t_done_c%0d", c),  128'(done[0]),   128'(c == 13));
            if (c == 1) begin
                check("t_en_c1",   128'(bram_en[0]), 128'(1));
                check("t_addr_c1", 128'(addr_a),     128'(0));
            end
        end
        check("t_frames", 128'(frames[0]), 128'(exp_frames[0]));
        step(2);

        // Backpressure: tready low for 5 cycles after two beats
        exp_frames[0]++;
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        for (int i = 0; i < 30 && beat[0] < 2; i++) step(1);
        check("bp_reach", 128'(beat[0] >= 2), 128'(1));
        tready[0] = 1'b0;
        step(5);
        tready[0] = 1'b1;
        wait_frames(3'b001);
        step(2);

        // start pulsed while busy must not queue a second frame
        exp_frames[0]++;
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(3);
        check("busy_mid", 128'(busy[0]), 128'(1));
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        wait_frames(3'b001);
        step(20);
        check("ign_frames", 128'(frames[0]), 128'(exp_frames[0]));
        check("ign_busy",   128'(busy[0]),   128'(0));
        check("ign_valid",  128'(tvalid[0]), 128'(0));

        // Random backpressure, latency 2 and latency 1 in parallel
        rnd_en = 3'b011;
        for (int f = 0; f < 20; f++) run_frame(3'b011);
        rnd_en = '0;
        tready = 3'b111;
        step(2);

        // Single-word frame: one beat with tlast in cycle 4, done in cycle 5
        exp_frames[2]++;
        start[2] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            start[2] = 1'b0;
            @(negedge clk);
            check($sformatf("one_valid_c%0d", c), 128'(tvalid[2]), 128'(c == 4));
            check($sformatf("one_last_c%0d", c),  128'(tlast[2]),  128'(c == 4));
            check($sformatf("one_done_c%0d", c),  128'(done[2]),   128'(c == 5));
        end
        step(2);

        // Reset after beat 3, then a clean frame from word 0
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        for (int i = 0; i < 30 && beat[0] < 4; i++) step(1);
        check("ar_reach", 128'(beat[0]), 128'(4));
        areset = 1'b1;
        #2;
        check("ar_busy",   128'(busy[0]),    128'(0));
        check("ar_done",   128'(done[0]),    128'(0));
        check("ar_en",     128'(bram_en[0]), 128'(0));
        check("ar_valid",  128'(tvalid[0]),  128'(0));
        check("ar_last",   128'(tlast[0]),   128'(0));
        check("ar_addr",   128'(addr_a),     128'(0));
        check("ar_tdata",  tdata[0],         128'(0));
        check("ar_nolast", 128'(lastc[0]),   128'(0));
        step(2);
        areset = 1'b0;
        step(1);
        run_frame(3'b001);
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
